fdiv_seq: RTL and testbench

Iterative single-precision IEEE-754 divider (y = x1 / x2) for the FPU datapath, alongside the combinational add/sub units. It is the sequential counterpart to the multiplier: restoring radix-2 mantissa division, one quotient bit per cycle. It uses a valid/ready handshake on both sides so the core can stall it. Denormal inputs and results flush to signed zero, matching the add/sub units' treatment of zero-exponent operands as non-normalised.

---
 rtl/fpu_pkg.sv | 27 ++
 rtl/fdiv_round.sv | 57 +++++
 rtl/fdiv_seq.sv | 126 ++++++++++++
 tb/tb_fdiv_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the iterative divider.
// FDIV_ROUND_EN selects round-to-nearest-even; without it results truncate.
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float32_t;

  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
  localparam int          FP_EXP_BIAS = 127;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;

  // Last counter value of the 26-step quotient loop.
  localparam logic [4:0]  DIV_LAST    = 5'd25;

  // Truncation never looks at the lowest quotient bit, so it is not routed.
`ifdef FDIV_ROUND_EN
  localparam int          Q_LSB       = 0;
`else
  localparam int          Q_LSB       = 1;
`endif

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} fdiv_state_t;

endpackage

// File: rtl/fdiv_round.sv
// Normalise, round (FDIV_ROUND_EN) or truncate, and range-check the raw quotient.
// Purely combinational; exp is e1 - e2 + 126 and is bumped when q[25] is set.
module fdiv_round
  import fpu_pkg::*;
(
  input  logic [25:Q_LSB]    q,
`ifdef FDIV_ROUND_EN
  input  logic [24:0]        r,
`endif
  input  logic signed [9:0]  exp,
  input  logic               sign,
  output logic [31:0]        y
);

  logic signed [9:0] e, e_r;
  logic [22:0]       frac, frac_r;
`ifdef FDIV_ROUND_EN
  logic              guard, sticky, inc, carry;
`endif

  always_comb begin
    e    = exp;
    frac = q[23:1];
`ifdef FDIV_ROUND_EN
    guard  = q[0];
    sticky = |r;
`endif
    if (q[25]) begin
      e    = exp + 10'sd1;
      frac = q[24:2];
`ifdef FDIV_ROUND_EN
      guard  = q[1];
      sticky = q[0] | (|r);
`endif
    end
  end

`ifdef FDIV_ROUND_EN
  assign inc             = guard & (sticky | frac[0]);
  // An all-ones fraction rounding up wraps to zero and moves the exponent.
  assign {carry, frac_r} = {1'b0, frac} + {23'h0, inc};
  assign e_r             = e + $signed({9'h0, carry});
`else
  assign frac_r = frac;
  assign e_r    = e;
`endif

  always_comb begin
    if (e <= 10'sd0)
      y = {sign, 31'h0};
    else if (e_r >= 10'sd255)
      y = {sign, FP_EXP_MAX, 23'h0};
    else
      y = {sign, e_r[7:0], frac_r};
  end

endmodule

// File: rtl/fdiv_seq.sv
// Iterative float32 divider, one quotient bit per cycle; FDIV_ROUND_EN enables RNE rounding.
// Latency 28 cycles (specials 1); result held in DONE until out_ready, in_ready only in IDLE.
module fdiv_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  fdiv_state_t       state, state_nxt;
  float32_t          a, b;
  logic [4:0]        cnt;
  logic [25:0]       q;
  logic [24:0]       r, diff;
  logic [23:0]       m2;
  logic signed [9:0] exp_q, exp_base;
  logic              sign_q, s;
  logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic              special;
  logic [31:0]       special_y, round_y;

  assign a      = x1;
  assign b      = x2;
  assign s      = a.sign ^ b.sign;
  assign a_zero = (a.exp == 8'h00);
  assign b_zero = (b.exp == 8'h00);
  assign a_inf  = (a.exp == FP_EXP_MAX) && (a.man == 23'h0);
  assign b_inf  = (b.exp == FP_EXP_MAX) && (b.man == 23'h0);
  assign a_nan  = (a.exp == FP_EXP_MAX) && (a.man != 23'h0);
  assign b_nan  = (b.exp == FP_EXP_MAX) && (b.man != 23'h0);

  assign exp_base = $signed({2'b00, a.exp}) - $signed({2'b00, b.exp})
                  + $signed(10'(FP_EXP_BIAS - 1));

  always_comb begin
    special   = 1'b1;
    special_y = FP_QNAN;
    if (a_nan || b_nan)
      special_y = FP_QNAN;
    else if ((a_inf && b_inf) || (a_zero && b_zero))
      special_y = FP_QNAN;
    else if (a_inf || b_zero)
      special_y = {s, FP_EXP_MAX, 23'h0};
    else if (a_zero || b_inf)
      special_y = {s, 31'h0};
    else
      special = 1'b0;
  end

  // r < 2*m2 always holds, so bit 24 of the difference is the borrow.
  assign diff = r - {1'b0, m2};

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE:    if (in_valid) state_nxt = special ? DONE : DIV;
      DIV:     if (cnt == DIV_LAST) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 5'd0;
      q      <= 26'h0;
      r      <= 25'h0;
      m2     <= 24'h0;
      exp_q  <= 10'sd0;
      sign_q <= 1'b0;
      y      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (special) begin
              y <= special_y;
            end else begin
              r      <= {2'b01, a.man};
              m2     <= {1'b1, b.man};
              q      <= 26'h0;
              cnt    <= 5'd0;
              exp_q  <= exp_base;
              sign_q <= s;
            end
          end
        end
        DIV: begin
          q   <= {q[24:0], ~diff[24]};
          r   <= {(diff[24] ? r[23:0] : diff[23:0]), 1'b0};
          cnt <= cnt + 5'd1;
        end
        ROUND:   y <= round_y;
        default: ;
      endcase
    end
  end

  fdiv_round u_round (
    .q    (q[25:Q_LSB]),
`ifdef FDIV_ROUND_EN
    .r    (r),
`endif
    .exp  (exp_q),
    .sign (sign_q),
    .y    (round_y)
  );

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed and randomised checks of fdiv_seq against an arithmetic reference model.
module tb_fdiv_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] x1, x2, y;

  int          checks = 0;
  int          errors = 0;
  int          lat;
  logic [31:0] ra, rb;
  logic [32:0] re;

`ifdef FDIV_ROUND_EN
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAA;
`endif

  always #5 clk = ~clk;

  fdiv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Returns {special, y}: special results appear one cycle after the handshake.
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int              ea, eb, ex;
    logic            s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, g, st;
    longint unsigned ma, mb, num, qq, frac;
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    s      = a[31] ^ b[31];
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    if (a_nan || b_nan)                               return {1'b1, 32'h7FC00000};
    if ((a_inf && b_inf) || (a_zero && b_zero))       return {1'b1, 32'h7FC00000};
    if (a_inf || b_zero)                              return {1'b1, s, 8'hFF, 23'h0};
    if (a_zero || b_inf)                              return {1'b1, s, 31'h0};
    ma  = {40'h0, 1'b1, a[22:0]};
    mb  = {40'h0, 1'b1, b[22:0]};
    num = ma << 25;
    qq  = num / mb;
    st  = (num % mb) != 0;
    if (qq >= (64'd1 << 25)) begin
      ex   = ea - eb + 127;
      frac = qq >> 2;
      g    = ((qq >> 1) & 1) != 0;
      st   = st || ((qq & 1) != 0);
    end else begin
      ex   = ea - eb + 126;
      frac = qq >> 1;
      g    = (qq & 1) != 0;
    end
    if (ex <= 0) return {1'b0, s, 31'h0};
`ifdef FDIV_ROUND_EN
    if (g && (st || ((frac & 1) != 0))) frac = frac + 1;
    if (frac == (64'd1 << 24)) begin
      frac = frac >> 1;
      ex   = ex + 1;
    end
`endif
    if (ex >= 255) return {1'b0, s, 8'hFF, 23'h0};
    return {1'b0, s, 8'(ex), 23'(frac)};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    logic [7:0]  e;
    v = $urandom;
    case ($urandom_range(0, 9))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2, 3:    e = 8'($urandom_range(0, 255));
      default: e = 8'($urandom_range(100, 154));
    endcase
    v[30:23] = e;
    if (e == 8'hFF && $urandom_range(0, 1) == 0) v[22:0] = 23'h0;
    return v;
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("start_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    x1 = a; x2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x1 = $urandom; x2 = $urandom;
  endtask

  task automatic wait_out(output int l);
    l = 1;
    while (!out_valid && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_y, input int exp_lat, input int hold);
    int l;
    out_ready = 1'b0;
    start(a, b);
    wait_out(l);
    check({tag, "_lat"}, 32'(l), 32'(exp_lat));
    check(tag, y, exp_y);
    repeat (hold) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x1 = 32'h0; x2 = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_y", y, 32'h0);

    run_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 28, 0);
    run_op("one_third", 32'h3F800000, 32'h40400000, ONE_THIRD, 28, 1);
    run_op("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0);
    run_op("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 1, 2);
    run_op("m2_by_inf", 32'hC0000000, 32'h7F800000, 32'h80000000, 1, 0);
    run_op("overflow", 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 28, 0);
    run_op("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 28, 0);

    // Backpressure: result must hold and new requests must be dropped.
    out_ready = 1'b0;
    start(32'h3F800000, 32'h40400000);
    wait_out(lat);
    check("bp_lat", 32'(lat), 32'd28);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x1 = 32'h40C00000; x2 = 32'h40000000;
      @(posedge clk); #1;
      check("bp_y", y, ONE_THIRD);
      check("bp_out_valid", {31'h0, out_valid}, 32'h1);
      check("bp_in_ready", {31'h0, in_ready}, 32'h0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_drop_valid", {31'h0, out_valid}, 32'h0);
    check("bp_rise_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    check("bp_not_queued", {31'h0, in_ready}, 32'h1);

    // Reset in the middle of a division discards it.
    out_ready = 1'b1;
    start(32'h40C00000, 32'h40000000);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_y", y, 32'h0);
    run_op("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 28, 0);

    for (int i = 0; i < 60; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      re = ref_div(ra, rb);
      run_op("rand", ra, rb, re[31:0], re[32] ? 1 : 28, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
